flag_int_ctrl: RTL and testbench
================================

Name: flag_int_ctrl

Overview:
- Sequenced flag and interrupt-state unit for the MCU datapath; owns the C, Z and I flag registers and their shadow copies.
- Arbitrates every flag-write source: ALU result, shadow restore, explicit set/clear, and interrupt entry.
- Gates the external interrupt request into a single INT_OUT strobe for the control unit.
- Sits between the ALU/flag-select muxing and the control-unit FSM; replaces the ad-hoc per-flag register/mux instances.

Parameters:
- INT_EDGE, 1, 1 = INT_REQ is rising-edge detected; 0 = INT_REQ is level-sensitive.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ALU_C  in  1  carry result from ALU
- ALU_Z  in  1  zero result from ALU
- FLG_C_LD  in  1  load C from selected source
- FLG_Z_LD  in  1  load Z from selected source
- FLG_C_SET  in  1  force C=1
- FLG_C_CLR  in  1  force C=0
- FLG_LD_SEL  in  1  load source: 0 = ALU, 1 = shadow
- FLG_SHAD_LD  in  1  copy C/Z into shadow (explicit)
- I_SET  in  1  set interrupt enable
- I_CLR  in  1  clear interrupt enable
- INT_REQ  in  1  external interrupt request, already synchronized
- INT_TAKEN  in  1  control unit has entered interrupt cycle
- RETI  in  1  control unit executing return-from-interrupt
- C_FLAG  out  1  carry flag register
- Z_FLAG  out  1  zero flag register
- SHAD_C  out  1  shadow carry
- SHAD_Z  out  1  shadow zero
- I_FLAG  out  1  interrupt enable
- INT_PEND  out  1  latched pending request
- IN_ISR  out  1  1 while in ISR state
- INT_OUT  out  1  interrupt strobe to control unit

Behaviour:
- One clock CLK; reset is asynchronous and active-high (RST). On RST every register output is 0 and the FSM is in NORMAL. INT_OUT is therefore also 0.
- All register updates happen on the CLK rising edge. Outputs are registered, except INT_OUT, which is combinational: INT_OUT = INT_PEND & I_FLAG & ~IN_ISR.
- C priority per cycle: FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold.
  - The load value is ALU_C when FLG_LD_SEL=0, SHAD_C when FLG_LD_SEL=1.
- Z: FLG_Z_LD loads ALU_Z (FLG_LD_SEL=0) or SHAD_Z (FLG_LD_SEL=1); otherwise Z holds.
- Shadow capture: SHAD_C/SHAD_Z load the current (pre-edge) C_FLAG/Z_FLAG when FLG_SHAD_LD=1 or INT_TAKEN=1.
  - If the same cycle also writes C/Z, the shadow gets the old value and the flags get the new value.
  - Shadow restore and shadow capture in the same cycle: flags take the old shadow, shadow takes the old flags (swap).
- I flag priority: INT_TAKEN (clear) > I_CLR > I_SET > hold.
- Pending latch:
  - Set condition, INT_EDGE=1: INT_REQ=1 while the previous-cycle INT_REQ=0 (edge register reset to 0).
  - Set condition, INT_EDGE=0: INT_REQ=1.
  - Cleared by INT_TAKEN; a clear in the same cycle as a new set wins (pending cleared).
  - Requests arriving while I_FLAG=0 or during the ISR remain latched.
- FSM, states NORMAL and ISR:
  - NORMAL -> ISR on INT_TAKEN. IN_ISR = 1 in ISR.
  - ISR -> NORMAL on RETI.
  - INT_TAKEN while already in ISR is a protocol error: the state stays ISR and the shadow is not overwritten.
  - RETI in NORMAL is ignored.
  - RETI does not touch flags itself; the control unit asserts FLG_LD_SEL=1 with FLG_C_LD/FLG_Z_LD, and I_SET/I_CLR, in the same cycle.
- Latency: flags visible 1 cycle after the load command. INT_OUT asserts in the same cycle as INT_PEND=1 when gating allows.

Decomposition:
- Shared package mcu_pkg: enum flag_src_t {FLG_SRC_ALU=0, FLG_SRC_SHAD=1}; enum int_state_t {INT_NORMAL, INT_ISR}.
- One sub-module, int_req_latch: edge detect plus pending set/clear logic, parameterized by INT_EDGE. The flag/shadow registers stay in the top module.

Test Plan:
- Reset mid-operation: C=1, Z=1, I=1, pending=1, RST pulse between clock edges -> all outputs 0 immediately; INT_OUT=0.
- C priority: ALU_C=1, FLG_C_LD=1, FLG_C_SET=1, FLG_C_CLR=1 -> C=0; drop CLR -> C=1; LD only with ALU_C=0 -> C=0.
- Interrupt entry:
  - Setup: C=1, Z=0, I=1, INT_REQ pulse -> INT_PEND=1, INT_OUT=1.
  - INT_TAKEN with FLG_Z_LD=1, ALU_Z=1 -> SHAD_C=1, SHAD_Z=0, Z=1, I=0, INT_PEND=0, IN_ISR=1.
- Return: in ISR with C=0, Z=1, SHAD C/Z=1/0; RETI with FLG_LD_SEL=1, both LDs, I_SET -> C=1, Z=0, I=1, IN_ISR=0.
- Masking: I=0, INT_EDGE=1, INT_REQ held high 5 cycles -> INT_PEND=1, INT_OUT=0; I_SET -> INT_OUT=1 the next cycle; no second pending after INT_TAKEN while INT_REQ is still high.
- Nested protection: in ISR, INT_TAKEN with flags changed -> SHAD_C/SHAD_Z unchanged, IN_ISR stays 1.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared MCU datapath types: flag load source select and interrupt FSM states.
package mcu_pkg;

  typedef enum logic {
    FLG_SRC_ALU  = 1'b0,
    FLG_SRC_SHAD = 1'b1
  } flag_src_t;

  typedef enum logic {
    INT_NORMAL = 1'b0,
    INT_ISR    = 1'b1
  } int_state_t;

endpackage

// File: rtl/int_req_latch.sv
// Interrupt request latch: optional rising-edge detect on INT_REQ plus the
// pending flag, which INT_TAKEN clears with priority over a new request.
module int_req_latch #(
  parameter bit INT_EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic int_taken,
  output logic int_pend
);

  logic req_q;
  logic req_set;

  // Previous-cycle request sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= int_req;
    end
  end

  always_comb begin
    req_set = 1'b0;
    if (INT_EDGE) begin
      req_set = int_req & ~req_q;
    end else begin
      req_set = int_req;
    end
  end

  // Requests stay latched regardless of masking or ISR state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_pend <= 1'b0;
    end else if (int_taken) begin
      int_pend <= 1'b0;
    end else if (req_set) begin
      int_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/flag_int_ctrl.sv
// C/Z/I flag registers with shadow copies, flag-write arbitration and the
// NORMAL/ISR interrupt state that gates INT_REQ into the INT_OUT strobe.
module flag_int_ctrl
  import mcu_pkg::*;
#(
  parameter bit INT_EDGE = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_REQ,
  input  logic INT_TAKEN,
  input  logic RETI,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic SHAD_C,
  output logic SHAD_Z,
  output logic I_FLAG,
  output logic INT_PEND,
  output logic IN_ISR,
  output logic INT_OUT
);

  int_state_t state;
  flag_src_t  ld_src;
  logic       c_ld_val;
  logic       z_ld_val;
  logic       shad_cap;

  // Load-source mux; a nested INT_TAKEN must not clobber the saved flags
  always_comb begin
    ld_src   = flag_src_t'(FLG_LD_SEL);
    c_ld_val = (ld_src == FLG_SRC_SHAD) ? SHAD_C : ALU_C;
    z_ld_val = (ld_src == FLG_SRC_SHAD) ? SHAD_Z : ALU_Z;
    shad_cap = FLG_SHAD_LD | (INT_TAKEN & (state == INT_NORMAL));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      C_FLAG <= 1'b0;
      Z_FLAG <= 1'b0;
      SHAD_C <= 1'b0;
      SHAD_Z <= 1'b0;
      I_FLAG <= 1'b0;
    end else begin
      if (FLG_C_CLR) begin
        C_FLAG <= 1'b0;
      end else if (FLG_C_SET) begin
        C_FLAG <= 1'b1;
      end else if (FLG_C_LD) begin
        C_FLAG <= c_ld_val;
      end

      if (FLG_Z_LD) begin
        Z_FLAG <= z_ld_val;
      end

      // Shadow takes pre-edge flags, so restore+capture in one cycle swaps
      if (shad_cap) begin
        SHAD_C <= C_FLAG;
        SHAD_Z <= Z_FLAG;
      end

      if (INT_TAKEN) begin
        I_FLAG <= 1'b0;
      end else if (I_CLR) begin
        I_FLAG <= 1'b0;
      end else if (I_SET) begin
        I_FLAG <= 1'b1;
      end
    end
  end

  // Interrupt state; IN_ISR is registered alongside the state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= INT_NORMAL;
      IN_ISR <= 1'b0;
    end else begin
      case (state)
        INT_NORMAL: begin
          if (INT_TAKEN) begin
            state  <= INT_ISR;
            IN_ISR <= 1'b1;
          end
        end
        INT_ISR: begin
          if (RETI) begin
            state  <= INT_NORMAL;
            IN_ISR <= 1'b0;
          end
        end
        default: begin
          state  <= INT_NORMAL;
          IN_ISR <= 1'b0;
        end
      endcase
    end
  end

  int_req_latch #(
    .INT_EDGE (INT_EDGE)
  ) u_int_req_latch (
    .clk       (CLK),
    .rst       (RST),
    .int_req   (INT_REQ),
    .int_taken (INT_TAKEN),
    .int_pend  (INT_PEND)
  );

  assign INT_OUT = INT_PEND & I_FLAG & ~IN_ISR;

endmodule

// File: tb/tb_flag_int_ctrl.sv
// Directed bench for flag_int_ctrl; output vector order is
// {C, Z, SHAD_C, SHAD_Z, I, INT_PEND, IN_ISR, INT_OUT}.
module tb_flag_int_ctrl;

  logic CLK = 1'b0;
  logic RST;
  logic ALU_C, ALU_Z, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_LD_SEL;
  logic FLG_SHAD_LD, I_SET, I_CLR, INT_REQ, INT_TAKEN, RETI;
  logic C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG, INT_PEND, IN_ISR, INT_OUT;

  int checks = 0;
  int errors = 0;

  wire [7:0] obs = {C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG, INT_PEND, IN_ISR, INT_OUT};

  flag_int_ctrl #(.INT_EDGE(1'b1)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ALU_C       (ALU_C),
    .ALU_Z       (ALU_Z),
    .FLG_C_LD    (FLG_C_LD),
    .FLG_Z_LD    (FLG_Z_LD),
    .FLG_C_SET   (FLG_C_SET),
    .FLG_C_CLR   (FLG_C_CLR),
    .FLG_LD_SEL  (FLG_LD_SEL),
    .FLG_SHAD_LD (FLG_SHAD_LD),
    .I_SET       (I_SET),
    .I_CLR       (I_CLR),
    .INT_REQ     (INT_REQ),
    .INT_TAKEN   (INT_TAKEN),
    .RETI        (RETI),
    .C_FLAG      (C_FLAG),
    .Z_FLAG      (Z_FLAG),
    .SHAD_C      (SHAD_C),
    .SHAD_Z      (SHAD_Z),
    .I_FLAG      (I_FLAG),
    .INT_PEND    (INT_PEND),
    .IN_ISR      (IN_ISR),
    .INT_OUT     (INT_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    ALU_C = 0; ALU_Z = 0; FLG_C_LD = 0; FLG_Z_LD = 0; FLG_C_SET = 0;
    FLG_C_CLR = 0; FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0;
    INT_TAKEN = 0; RETI = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle();
    INT_REQ = 0;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL reset_init: got %b expected %b", obs, 8'b0000_0000);
    end
    RST = 0;
    // Build up C=1, Z=1, I=1, pending=1
    FLG_C_SET = 1; ALU_Z = 1; FLG_Z_LD = 1; I_SET = 1; INT_REQ = 1;
    step();
    idle(); INT_REQ = 0;
    checks++;
    if (obs !== 8'b1100_1101) begin
      errors++; $display("FAIL reset_setup: got %b expected %b", obs, 8'b1100_1101);
    end
    #2 RST = 1;
    #1;
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL reset_midop: got %b expected %b", obs, 8'b0000_0000);
    end
    #1 RST = 0;
  endtask

  task automatic test_c_priority();
    idle(); FLG_C_SET = 1;
    step();
    checks++;
    if (obs !== 8'b1000_0000) begin
      errors++; $display("FAIL c_set: got %b expected %b", obs, 8'b1000_0000);
    end
    idle(); ALU_C = 1; FLG_C_LD = 1; FLG_C_SET = 1; FLG_C_CLR = 1;
    step();
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL c_clr_wins: got %b expected %b", obs, 8'b0000_0000);
    end
    FLG_C_CLR = 0;
    step();
    checks++;
    if (obs !== 8'b1000_0000) begin
      errors++; $display("FAIL c_set_over_ld: got %b expected %b", obs, 8'b1000_0000);
    end
    idle(); ALU_C = 0; FLG_C_LD = 1;
    step();
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL c_ld_alu0: got %b expected %b", obs, 8'b0000_0000);
    end
    idle(); ALU_C = 0; FLG_C_LD = 1; FLG_C_SET = 1;
    step();
    checks++;
    if (obs !== 8'b1000_0000) begin
      errors++; $display("FAIL c_set_alu0: got %b expected %b", obs, 8'b1000_0000);
    end
    idle(); ALU_C = 0; FLG_C_LD = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b0000_0000) begin
      errors++; $display("FAIL c_ld_back: got %b expected %b", obs, 8'b0000_0000);
    end
  endtask

  task automatic test_int_entry();
    idle(); FLG_C_SET = 1; I_SET = 1; INT_REQ = 1;
    step();
    idle(); INT_REQ = 0;
    checks++;
    if (obs !== 8'b1000_1101) begin
      errors++; $display("FAIL entry_setup: got %b expected %b", obs, 8'b1000_1101);
    end
    INT_TAKEN = 1; FLG_Z_LD = 1; ALU_Z = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1110_0010) begin
      errors++; $display("FAIL entry_taken: got %b expected %b", obs, 8'b1110_0010);
    end
  endtask

  task automatic test_nested();
    idle(); INT_TAKEN = 1; FLG_C_CLR = 1; FLG_Z_LD = 1; ALU_Z = 0;
    step();
    idle();
    checks++;
    if (obs !== 8'b0010_0010) begin
      errors++; $display("FAIL nested_taken: got %b expected %b", obs, 8'b0010_0010);
    end
  endtask

  task automatic test_return();
    idle(); FLG_Z_LD = 1; ALU_Z = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b0110_0010) begin
      errors++; $display("FAIL ret_setup: got %b expected %b", obs, 8'b0110_0010);
    end
    RETI = 1; FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; I_SET = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1010_1000) begin
      errors++; $display("FAIL reti: got %b expected %b", obs, 8'b1010_1000);
    end
    RETI = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1010_1000) begin
      errors++; $display("FAIL reti_normal: got %b expected %b", obs, 8'b1010_1000);
    end
    // Restore and capture together swap flags and shadow
    FLG_C_CLR = 1; FLG_Z_LD = 1; ALU_Z = 1;
    step();
    idle();
    FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; FLG_SHAD_LD = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1001_1000) begin
      errors++; $display("FAIL swap: got %b expected %b", obs, 8'b1001_1000);
    end
  endtask

  task automatic test_masking();
    idle(); I_CLR = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1001_0000) begin
      errors++; $display("FAIL mask_iclr: got %b expected %b", obs, 8'b1001_0000);
    end
    INT_REQ = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== 8'b1001_0100) begin
        errors++; $display("FAIL mask_hold%0d: got %b expected %b", i, obs, 8'b1001_0100);
      end
    end
    I_SET = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1001_1101) begin
      errors++; $display("FAIL mask_iset: got %b expected %b", obs, 8'b1001_1101);
    end
    INT_TAKEN = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1010_0010) begin
      errors++; $display("FAIL mask_taken: got %b expected %b", obs, 8'b1010_0010);
    end
    repeat (2) step();
    checks++;
    if (obs !== 8'b1010_0010) begin
      errors++; $display("FAIL mask_no_repend: got %b expected %b", obs, 8'b1010_0010);
    end
    INT_REQ = 0; RETI = 1;
    step();
    idle();
    checks++;
    if (obs !== 8'b1010_0000) begin
      errors++; $display("FAIL mask_reti: got %b expected %b", obs, 8'b1010_0000);
    end
  endtask

  initial begin
    test_reset();
    test_c_priority();
    test_int_entry();
    test_nested();
    test_return();
    test_masking();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
